// File: rtl/skew_writeback.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | skew_writeback: de-skews staggered PE lane results into aligned rows,    |
// | buffers them and writes them to SRAM. Optional: SKEW_WB_CHECK_EN.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module skew_writeback #(
  parameter int LANES      = 8,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 16,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [CNT_W-1:0]        row_count,
  input  logic [LANES-1:0]        res_valid,
  input  logic [LANES*DATA_W-1:0] res_data,
  output logic                    wr_en,
  input  logic                    wr_ready,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [LANES*DATA_W-1:0] wr_data,
  output logic                    busy,
  output logic                    done,
  output logic                    ovf_err,
  output logic                    skew_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ROW_W = LANES * DATA_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic [LANES-1:0] w_dly_valid;
  logic [ROW_W-1:0] w_dly_data;

  // Lane i is delayed so that it lines up with lane LANES-1 (no delay).
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int STAGES = LANES - 1 - i;
    if (STAGES == 0) begin : g_pass
      assign w_dly_valid[i]                   = res_valid[i];
      assign w_dly_data[i*DATA_W +: DATA_W]   = res_data[i*DATA_W +: DATA_W];
    end else begin : g_dly
      logic [DATA_W-1:0] r_data_sr [STAGES];
      logic [STAGES-1:0] r_vld_sr;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_vld_sr <= '0;
          for (int s = 0; s < STAGES; s++) r_data_sr[s] <= '0;
        end else begin
          r_vld_sr[0]  <= res_valid[i];
          r_data_sr[0] <= res_data[i*DATA_W +: DATA_W];
          for (int s = 1; s < STAGES; s++) begin
            r_vld_sr[s]  <= r_vld_sr[s-1];
            r_data_sr[s] <= r_data_sr[s-1];
          end
        end
      end
      assign w_dly_valid[i]                 = r_vld_sr[STAGES-1];
      assign w_dly_data[i*DATA_W +: DATA_W] = r_data_sr[STAGES-1];
    end
  end

  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_row_count, r_rows_seen, r_rows_written;
  logic              r_align_valid;
  logic [ROW_W-1:0]  r_align_data;
  logic              r_ovf;

  logic [ROW_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]    r_count;

  logic w_row_evt, w_accept, w_excess, w_full, w_empty, w_push, w_pop, w_drop;
  logic w_skew_mis;

  assign w_row_evt = w_dly_valid[0];
  assign w_accept  = w_row_evt && (r_state == S_RUN) && (r_rows_seen < r_row_count);
  assign w_excess  = w_row_evt && ((r_state == S_DRAIN) ||
                     ((r_state == S_RUN) && (r_rows_seen >= r_row_count)));

  assign w_full  = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = wr_en && wr_ready;
  // A full FIFO still takes a row when the head leaves in the same cycle.
  assign w_push  = r_align_valid && (!w_full || w_pop);
  assign w_drop  = r_align_valid && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_align_valid <= 1'b0;
      r_align_data  <= '0;
    end else begin
      r_align_valid <= w_accept;
      if (w_accept) r_align_data <= w_dly_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_align_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = (row_count == '0) ? S_DONE : S_RUN;
      S_RUN:   if (w_accept && (r_rows_seen + CNT_W'(1) == r_row_count)) w_state_nxt = S_DRAIN;
      // Finish the cycle the last write is accepted so done follows it directly.
      S_DRAIN: if (!r_align_valid &&
                   (w_empty || ((r_count == (PTR_W+1)'(1)) && w_pop))) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_base         <= '0;
      r_row_count    <= '0;
      r_rows_seen    <= '0;
      r_rows_written <= '0;
      r_ovf          <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && start) begin
        r_base         <= base_addr;
        r_row_count    <= row_count;
        r_rows_seen    <= '0;
        r_rows_written <= '0;
        r_ovf          <= 1'b0;
      end else begin
        if (w_accept)          r_rows_seen    <= r_rows_seen + CNT_W'(1);
        if (w_pop)             r_rows_written <= r_rows_written + CNT_W'(1);
        if (w_excess || w_drop) r_ovf         <= 1'b1;
      end
    end
  end

`ifdef SKEW_WB_CHECK_EN
  logic r_skew;
  assign w_skew_mis = busy && (w_dly_valid != {LANES{w_dly_valid[0]}});
  always_ff @(posedge clk) begin
    if (rst)                            r_skew <= 1'b0;
    else if ((r_state == S_IDLE) && start) r_skew <= 1'b0;
    else if (w_skew_mis)                r_skew <= 1'b1;
  end
  assign skew_err = r_skew;
`else
  logic unused_lane_valid;
  assign w_skew_mis        = 1'b0;
  assign unused_lane_valid = ^{w_skew_mis, w_dly_valid[LANES-1:1]};
  assign skew_err          = 1'b0;
`endif

  assign wr_en   = !w_empty;
  assign wr_data = w_empty ? '0 : r_mem[r_rd_ptr];
  assign wr_addr = r_base + ADDR_W'(r_rows_written);
  assign busy    = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done    = (r_state == S_DONE);
  assign ovf_err = r_ovf;

endmodule
`default_nettype wire
